// File: rtl/som_update_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : som_update_sequencer_if
// Description : Weight-RAM bus between the SOM update sequencer and the
//               weight memory. The sequencer drives the bus through the
//               master modport, and the RAM answers through the slave modport.
//               Read data is valid the cycle after w_rd.
//   w_addr  [3:0]      neuron index being accessed
//   w_rd               read strobe
//   w_rdata [3*CH_W-1] read data (R,G,B packed, R in the MSBs)
//   w_wr               write strobe
//   w_wdata [3*CH_W-1] write data
// Revision    : 1.0 - initial release
// ============================================================================
interface som_update_sequencer_if #(
    parameter int CH_W = 8
);
    logic [3:0]          w_addr;
    logic                w_rd;
    logic [3*CH_W-1:0]   w_rdata;
    logic                w_wr;
    logic [3*CH_W-1:0]   w_wdata;

    modport master (
        output w_addr,
        output w_rd,
        output w_wr,
        output w_wdata,
        input  w_rdata
    );

    modport slave (
        input  w_addr,
        input  w_rd,
        input  w_wr,
        input  w_wdata,
        output w_rdata
    );
endinterface
`default_nettype wire

// File: rtl/som_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : som_update_sequencer
// Description : Weight-update sweep for one SOM training sample. On start,
//               the module latches the BMU index, epoch and pixel. It then
//               walks neurons 0..15 of the 4x4 map. Each neuron inside the
//               epoch-dependent Manhattan neighbourhood gets one weight-RAM
//               read followed by one write. The write pulls each channel
//               toward the pixel by 2^-(1+phase+dist). done pulses at the
//               end of the sweep.
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle sweep request (accepted only when idle)
//   bmu_idx [3:0]       winning neuron index
//   epoch   [7:0]       epoch; bits [7:6] select the training phase
//   pixel_in[23:0]      training sample, R/G/B = [23:16]/[15:8]/[7:0]
//   wbus                weight-RAM bus (master side)
//   busy                sweep in progress
//   done                one-cycle end-of-sweep pulse
// Revision    : 1.0 - initial release
// ============================================================================
module som_update_sequencer #(
    parameter int N_SIDE = 4,
    parameter int CH_W   = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start,
    input  wire logic [3:0]          bmu_idx,
    input  wire logic [7:0]          epoch,
    input  wire logic [3*CH_W-1:0]   pixel_in,
    som_update_sequencer_if.master   wbus,
    output logic                     busy,
    output logic                     done
);

    localparam logic [3:0] c_LAST_IDX = 4'(N_SIDE * N_SIDE - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_READ  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [3:0]          r_n;
    logic [3:0]          w_n_nxt;
    logic [3:0]          r_bmu;
    logic [1:0]          r_phase;
    logic [3*CH_W-1:0]   r_pixel;

    logic [1:0]          w_drow;
    logic [1:0]          w_dcol;
    logic [2:0]          w_dist;
    logic [1:0]          w_radius;
    logic                w_in_nbhd;
    logic [3:0]          w_shift;
    logic [3*CH_W-1:0]   w_upd;
    logic                w_unused_epoch;

    // Only the phase bits of the epoch affect the update.
    assign w_unused_epoch = ^epoch[5:0];

    // ------------------------------------------------------------------
    // Neighbourhood and learning-rate decode for the current neuron
    // ------------------------------------------------------------------
    assign w_drow    = (r_n[3:2] >= r_bmu[3:2]) ? (r_n[3:2] - r_bmu[3:2])
                                                : (r_bmu[3:2] - r_n[3:2]);
    assign w_dcol    = (r_n[1:0] >= r_bmu[1:0]) ? (r_n[1:0] - r_bmu[1:0])
                                                : (r_bmu[1:0] - r_n[1:0]);
    assign w_dist    = {1'b0, w_drow} + {1'b0, w_dcol};
    assign w_radius  = 2'd3 - r_phase;
    assign w_in_nbhd = (w_dist <= {1'b0, w_radius});
    // Stays within 1..4 for every neuron that reaches WRITE. It is 4 bits
    // wide so that the out-of-neighbourhood sum cannot wrap.
    assign w_shift   = 4'd1 + {2'b00, r_phase} + {1'b0, w_dist};

    // ------------------------------------------------------------------
    // Per-channel update: w + ((x - w) >>> shift). The signed floor shift
    // keeps the result between w and x, so no saturation is needed.
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [CH_W-1:0]        w_x;
        logic [CH_W-1:0]        w_w;
        logic signed [CH_W:0]   w_diff;
        logic signed [CH_W:0]   w_step;

        assign w_x    = r_pixel[ch*CH_W +: CH_W];
        assign w_w    = wbus.w_rdata[ch*CH_W +: CH_W];
        assign w_diff = $signed({1'b0, w_x}) - $signed({1'b0, w_w});
        assign w_step = w_diff >>> w_shift;
        assign w_upd[ch*CH_W +: CH_W] = w_w + w_step[CH_W-1:0];
    end

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_n     <= 4'd0;
            r_bmu   <= 4'd0;
            r_phase <= 2'd0;
            r_pixel <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            // Operands are captured only on an accepted start.
            if (r_state == c_ST_IDLE && start) begin
                r_bmu   <= bmu_idx;
                r_phase <= epoch[7:6];
                r_pixel <= pixel_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and neuron-counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_CHECK;
                    w_n_nxt     = 4'd0;
                end
            end
            c_ST_CHECK: begin
                if (w_in_nbhd) begin
                    w_state_nxt = c_ST_READ;
                end else if (r_n == c_LAST_IDX) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_n_nxt = r_n + 4'd1;
                end
            end
            c_ST_READ: begin
                w_state_nxt = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (r_n == c_LAST_IDX) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_state_nxt = c_ST_CHECK;
                    w_n_nxt     = r_n + 4'd1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decode directly from state
    // ------------------------------------------------------------------
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        wbus.w_rd    = 1'b0;
        wbus.w_wr    = 1'b0;
        wbus.w_addr  = 4'd0;
        wbus.w_wdata = '0;
        case (r_state)
            c_ST_CHECK: begin
                busy        = 1'b1;
                wbus.w_addr = r_n;
            end
            c_ST_READ: begin
                busy        = 1'b1;
                wbus.w_rd   = 1'b1;
                wbus.w_addr = r_n;
            end
            c_ST_WRITE: begin
                busy         = 1'b1;
                wbus.w_wr    = 1'b1;
                wbus.w_addr  = r_n;
                wbus.w_wdata = w_upd;
            end
            c_ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_som_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_som_update_sequencer
// Description : Scoreboard bench for som_update_sequencer. Each directed
//               sweep pushes its hand-computed (address, data) writes into a
//               queue. A monitor pops and compares on every w_wr. The
//               stimulus side checks the done latency and a few RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_som_update_sequencer;

    typedef struct {
        logic [3:0]  addr;
        logic [23:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  bmu_idx;
    logic [7:0]  epoch;
    logic [23:0] pixel_in;
    logic        busy;
    logic        done;

    som_update_sequencer_if #(.CH_W(8)) wbus ();

    som_update_sequencer #(.N_SIDE(4), .CH_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bmu_idx  (bmu_idx),
        .epoch    (epoch),
        .pixel_in (pixel_in),
        .wbus     (wbus.master),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  tests;
    int  fails;
    wr_t exp_q[$];
    bit  mon_en;

    // ------------------------------------------------------------------
    // Weight RAM model: one-cycle read latency
    // ------------------------------------------------------------------
    logic [23:0] mem [16];
    logic [23:0] r_rdata;
    logic        mem_init;
    logic [23:0] init_val;
    logic        poke_en;
    logic [3:0]  poke_addr;
    logic [23:0] poke_data;

    assign wbus.w_rdata = r_rdata;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val;
        end else begin
            if (poke_en)   mem[poke_addr] <= poke_data;
            if (wbus.w_wr) mem[wbus.w_addr] <= wbus.w_wdata;
        end
        if (wbus.w_rd) r_rdata <= mem[wbus.w_addr];
    end

    // ------------------------------------------------------------------
    // Monitor: compare every write against the scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (wbus.w_rd && wbus.w_wr) begin
                tests++;
                fails++;
                $display("FAIL rd_wr_overlap: w_rd and w_wr both high at addr %0d", wbus.w_addr);
            end
            if (wbus.w_wr) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %06h, none expected",
                             wbus.w_addr, wbus.w_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wbus.w_addr !== e.addr || wbus.w_wdata !== e.data) begin
                        fails++;
                        $display("FAIL write: got addr %0d data %06h, expected addr %0d data %06h",
                                 wbus.w_addr, wbus.w_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [23:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic load_mem(input logic [23:0] v);
        @(negedge clk);
        init_val = v;
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    task automatic poke(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // The expected writes for bmu=0, epoch=0, zero weights and a white pixel.
    task automatic push_bmu0_white();
        push(4'd0,  24'h7F7F7F);
        push(4'd1,  24'h3F3F3F);
        push(4'd2,  24'h1F1F1F);
        push(4'd3,  24'h0F0F0F);
        push(4'd4,  24'h3F3F3F);
        push(4'd5,  24'h1F1F1F);
        push(4'd6,  24'h0F0F0F);
        push(4'd8,  24'h1F1F1F);
        push(4'd9,  24'h0F0F0F);
        push(4'd12, 24'h0F0F0F);
    endtask

    // cyc counts cycles after the accepting edge: 1 is the first CHECK cycle.
    // glitch > 0 pulses start with a different BMU at that cycle.
    task automatic run_sweep(input string name, input logic [3:0] b, input logic [7:0] ep,
                             input logic [23:0] px, input int exp_done, input int glitch);
        int cyc;
        @(negedge clk);
        bmu_idx  = b;
        epoch    = ep;
        pixel_in = px;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 120) begin
            if (glitch > 0 && cyc == glitch) begin
                start    = 1'b1;
                bmu_idx  = 4'd15;
                epoch    = 8'd192;
                pixel_in = 24'h000000;
            end else if (glitch > 0 && cyc == glitch + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, cyc, exp_done);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, done}, 0);
        chk({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int w;
        tests     = 0;
        fails     = 0;
        mon_en    = 1'b1;
        rst       = 1'b1;
        start     = 1'b0;
        bmu_idx   = 4'd0;
        epoch     = 8'd0;
        pixel_in  = 24'd0;
        mem_init  = 1'b0;
        init_val  = 24'd0;
        poke_en   = 1'b0;
        poke_addr = 4'd0;
        poke_data = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    {31'd0, busy},         0);
        chk("rst_done",    {31'd0, done},         0);
        chk("rst_w_rd",    {31'd0, wbus.w_rd},    0);
        chk("rst_w_wr",    {31'd0, wbus.w_wr},    0);
        chk("rst_w_addr",  {28'd0, wbus.w_addr},  0);
        chk("rst_w_wdata", {8'd0,  wbus.w_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        // bmu 0, radius 3: 10 neighbours
        load_mem(24'h000000);
        push_bmu0_white();
        run_sweep("bmu0", 4'd0, 8'd0, 24'hFFFFFF, 37, 0);

        // bmu 5, phase 1, radius 2: 11 neighbours, shift = 2 + dist
        load_mem(24'h000000);
        push(4'd0,  24'h0F0F0F);
        push(4'd1,  24'h1F1F1F);
        push(4'd2,  24'h0F0F0F);
        push(4'd4,  24'h1F1F1F);
        push(4'd5,  24'h3F3F3F);
        push(4'd6,  24'h1F1F1F);
        push(4'd7,  24'h0F0F0F);
        push(4'd8,  24'h0F0F0F);
        push(4'd9,  24'h1F1F1F);
        push(4'd10, 24'h0F0F0F);
        push(4'd13, 24'h0F0F0F);
        run_sweep("bmu5", 4'd5, 8'd64, 24'hFFFFFF, 39, 0);
        chk("bmu5_untouched3",  {8'd0, mem[3]},  0);
        chk("bmu5_untouched12", {8'd0, mem[12]}, 0);
        chk("bmu5_untouched15", {8'd0, mem[15]}, 0);

        // bmu 10, phase 3: only the BMU, shift 4, downward step
        load_mem(24'h000000);
        poke(4'd10, 24'h808080);
        push(4'd10, 24'h787878);
        run_sweep("bmu10", 4'd10, 8'd192, 24'h000000, 19, 0);
        chk("bmu10_mem", {8'd0, mem[10]}, 32'h787878);

        // Negative floor rounding: -1 >>> k stays -1, so 0x01 goes to 0x00.
        load_mem(24'h010101);
        for (int a = 0; a < 16; a++) begin
            if (a inside {0, 1, 2, 3, 4, 5, 6, 8, 9, 12}) push(4'(a), 24'h000000);
        end
        run_sweep("neg_round", 4'd0, 8'd0, 24'h000000, 37, 0);
        chk("neg_round_mem0", {8'd0, mem[0]}, 0);

        // start with a different operand set mid-sweep is ignored
        load_mem(24'h000000);
        push_bmu0_white();
        run_sweep("midstart", 4'd0, 8'd0, 24'hFFFFFF, 37, 6);

        // Reset asserted during the first WRITE cycle
        mon_en = 1'b0;
        load_mem(24'h000000);
        @(negedge clk);
        bmu_idx  = 4'd0;
        epoch    = 8'd0;
        pixel_in = 24'hFFFFFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!wbus.w_wr && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("rstw_reached_write", {31'd0, wbus.w_wr}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_w_wr",   {31'd0, wbus.w_wr},   0);
        chk("rstw_w_rd",   {31'd0, wbus.w_rd},   0);
        chk("rstw_busy",   {31'd0, busy},        0);
        chk("rstw_done",   {31'd0, done},        0);
        chk("rstw_w_addr", {28'd0, wbus.w_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_kept_write", {8'd0, mem[0]}, 32'h7F7F7F);
        mon_en = 1'b1;

        // A clean full sweep after reset
        load_mem(24'h000000);
        push_bmu0_white();
        run_sweep("post_rst", 4'd0, 8'd0, 24'hFFFFFF, 37, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
